// File: rtl/mem_arbiter_if.sv
// Shared memory-port bundle: fetch and data requesters on one side,
// the single memory array on the other.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [3:0]        d_be;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic [31:0]       mem_rdata;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata, d_be,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter and latency sequencer for the shared memory port.
// Optional fetch starvation guard: define ARB_STARVE_GUARD_EN.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input logic           clk,
  input logic           rst_n,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        own_d_q, own_d_d;
  logic        st_q, st_d;
  logic        if_rv_q, if_rv_d;
  logic        d_rv_q, d_rv_d;
  logic [31:0] if_rd_q, if_rd_d;
  logic [31:0] d_rd_q, d_rd_d;

  logic              idle;
  logic              force_if;
  logic              gnt_d;
  logic              gnt_i;
  logic              issue;
  logic [ADDR_W-1:0] addr_sel;

  // Gated by rst_n so grants and strobes drop the instant reset asserts.
  assign idle  = rst_n && (state_q == IDLE);
  assign gnt_d = idle && bus.d_req && !force_if;
  assign gnt_i = idle && bus.if_req && !gnt_d;
  assign issue = gnt_d || gnt_i;

`ifdef ARB_STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_MAX + 1);

  logic [SC_W-1:0] sc_q, sc_d;

  assign force_if = bus.if_req && (sc_q == SC_W'(STARVE_MAX));

  always_comb begin
    sc_d = sc_q;
    if (idle) begin
      if (gnt_i || !bus.if_req) begin
        sc_d = '0;
      end else if (gnt_d) begin
        sc_d = sc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_q <= '0;
    end else begin
      sc_q <= sc_d;
    end
  end
`else
  logic starve_unused;
  assign starve_unused = (STARVE_MAX != 0);
  assign force_if      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    own_d_d = own_d_q;
    st_d    = st_q;
    if_rv_d = 1'b0;
    d_rv_d  = 1'b0;
    if_rd_d = if_rd_q;
    d_rd_d  = d_rd_q;
    unique case (state_q)
      IDLE: begin
        if (issue) begin
          own_d_d = gnt_d;
          st_d    = gnt_d && bus.d_we;
          cnt_d   = LAT_M1;
          state_d = (MEM_LAT > 1) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= 3'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (own_d_q) begin
          d_rv_d = 1'b1;
          d_rd_d = st_q ? 32'h0 : bus.mem_rdata;
        end else begin
          if_rv_d = 1'b1;
          if_rd_d = bus.mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      own_d_q <= 1'b0;
      st_q    <= 1'b0;
      if_rv_q <= 1'b0;
      d_rv_q  <= 1'b0;
      if_rd_q <= '0;
      d_rd_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      own_d_q <= own_d_d;
      st_q    <= st_d;
      if_rv_q <= if_rv_d;
      d_rv_q  <= d_rv_d;
      if_rd_q <= if_rd_d;
      d_rd_q  <= d_rd_d;
    end
  end

  assign addr_sel = gnt_d ? bus.d_addr : bus.if_addr;

  assign bus.if_gnt    = gnt_i;
  assign bus.d_gnt     = gnt_d;
  assign bus.mem_req   = issue;
  assign bus.mem_we    = gnt_d && bus.d_we;
  assign bus.mem_addr  = issue ? addr_sel : '0;
  assign bus.mem_wdata = gnt_d ? bus.d_wdata : 32'h0;
  assign bus.mem_be    = gnt_d ? bus.d_be : (gnt_i ? 4'hF : 4'h0);

  assign bus.if_rvalid = if_rv_q;
  assign bus.if_rdata  = if_rd_q;
  assign bus.d_rvalid  = d_rv_q;
  assign bus.d_rdata   = d_rd_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed cycle-table bench for mem_arbiter with MEM_LAT=2,
// plus hand sequences for starvation and mid-transaction reset.
module tb_mem_arbiter;

  logic clk;
  logic rst_n;

  mem_arbiter_if #(.ADDR_W(32)) bus ();

  mem_arbiter #(
    .ADDR_W(32),
    .MEM_LAT(2),
    .STARVE_MAX(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [31:0] mem_rdata;
  } in_t;

  typedef struct packed {
    logic        if_gnt;
    logic        d_gnt;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_rvalid;
    logic [31:0] d_rdata;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  vec_t tab[$];

  function automatic in_t mk_in(
    logic ir, logic [31:0] ia, logic dr, logic dw,
    logic [31:0] da, logic [31:0] dwd, logic [3:0] be,
    logic [31:0] mr);
    in_t r;
    r.if_req = ir; r.if_addr = ia; r.d_req = dr; r.d_we = dw;
    r.d_addr = da; r.d_wdata = dwd; r.d_be = be; r.mem_rdata = mr;
    return r;
  endfunction

  function automatic out_t mk_out(
    logic ig, logic dg, logic mq, logic mw,
    logic [31:0] ma, logic [31:0] mwd, logic [3:0] mbe,
    logic irv, logic [31:0] ird, logic drv, logic [31:0] drd);
    out_t r;
    r.if_gnt = ig; r.d_gnt = dg; r.mem_req = mq; r.mem_we = mw;
    r.mem_addr = ma; r.mem_wdata = mwd; r.mem_be = mbe;
    r.if_rvalid = irv; r.if_rdata = ird;
    r.d_rvalid = drv; r.d_rdata = drd;
    return r;
  endfunction

  function automatic vec_t row(in_t i, out_t o);
    vec_t r;
    r.i = i;
    r.o = o;
    return r;
  endfunction

  function automatic out_t sample();
    out_t r;
    r.if_gnt = bus.if_gnt; r.d_gnt = bus.d_gnt;
    r.mem_req = bus.mem_req; r.mem_we = bus.mem_we;
    r.mem_addr = bus.mem_addr; r.mem_wdata = bus.mem_wdata;
    r.mem_be = bus.mem_be;
    r.if_rvalid = bus.if_rvalid; r.if_rdata = bus.if_rdata;
    r.d_rvalid = bus.d_rvalid; r.d_rdata = bus.d_rdata;
    return r;
  endfunction

  task automatic drive(in_t v);
    bus.if_req = v.if_req; bus.if_addr = v.if_addr;
    bus.d_req = v.d_req; bus.d_we = v.d_we;
    bus.d_addr = v.d_addr; bus.d_wdata = v.d_wdata;
    bus.d_be = v.d_be; bus.mem_rdata = v.mem_rdata;
  endtask

  task automatic check(string nm, out_t e);
    out_t a;
    a = sample();
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic check_bit(string nm, logic a, logic e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %b want %b", nm, a, e);
    end
  endtask

  out_t z;
  in_t  i0;

  initial begin
    z  = mk_out(0,0,0,0,0,0,0,0,0,0,0);
    i0 = mk_in(0,0,0,0,0,0,0,0);

    // single fetch
    tab.push_back(row(i0, z));
    tab.push_back(row(mk_in(1,8,0,0,0,0,0,0),
      mk_out(1,0,1,0,8,0,4'hF,0,0,0,0)));
    tab.push_back(row(i0, z));
    tab.push_back(row(mk_in(0,0,0,0,0,0,0,32'h00500093), z));
    tab.push_back(row(i0, mk_out(0,0,0,0,0,0,0,1,32'h00500093,0,0)));
    tab.push_back(row(i0, mk_out(0,0,0,0,0,0,0,0,32'h00500093,0,0)));
    // simultaneous load + fetch
    tab.push_back(row(mk_in(1,0,1,0,9,0,4'hF,0),
      mk_out(0,1,1,0,9,0,4'hF,0,32'h00500093,0,0)));
    tab.push_back(row(mk_in(1,0,0,0,0,0,0,0),
      mk_out(0,0,0,0,0,0,0,0,32'h00500093,0,0)));
    tab.push_back(row(mk_in(1,0,0,0,0,0,0,32'h11223344),
      mk_out(0,0,0,0,0,0,0,0,32'h00500093,0,0)));
    tab.push_back(row(mk_in(1,0,0,0,0,0,0,0),
      mk_out(1,0,1,0,0,0,4'hF,0,32'h00500093,1,32'h11223344)));
    tab.push_back(row(i0,
      mk_out(0,0,0,0,0,0,0,0,32'h00500093,0,32'h11223344)));
    tab.push_back(row(mk_in(0,0,0,0,0,0,0,32'hAABBCCDD),
      mk_out(0,0,0,0,0,0,0,0,32'h00500093,0,32'h11223344)));
    tab.push_back(row(i0,
      mk_out(0,0,0,0,0,0,0,1,32'hAABBCCDD,0,32'h11223344)));
    // store
    tab.push_back(row(mk_in(0,0,1,1,9,14,4'hF,0),
      mk_out(0,1,1,1,9,32'hE,4'hF,0,32'hAABBCCDD,0,32'h11223344)));
    tab.push_back(row(i0,
      mk_out(0,0,0,0,0,0,0,0,32'hAABBCCDD,0,32'h11223344)));
    tab.push_back(row(mk_in(0,0,0,0,0,0,0,32'hDEADBEEF),
      mk_out(0,0,0,0,0,0,0,0,32'hAABBCCDD,0,32'h11223344)));
    tab.push_back(row(i0, mk_out(0,0,0,0,0,0,0,0,32'hAABBCCDD,1,0)));
    // back-to-back fetches
    tab.push_back(row(mk_in(1,0,0,0,0,0,0,0),
      mk_out(1,0,1,0,0,0,4'hF,0,32'hAABBCCDD,0,0)));
    tab.push_back(row(mk_in(1,4,0,0,0,0,0,0),
      mk_out(0,0,0,0,0,0,0,0,32'hAABBCCDD,0,0)));
    tab.push_back(row(mk_in(1,4,0,0,0,0,0,32'h13),
      mk_out(0,0,0,0,0,0,0,0,32'hAABBCCDD,0,0)));
    tab.push_back(row(mk_in(1,4,0,0,0,0,0,0),
      mk_out(1,0,1,0,4,0,4'hF,1,32'h13,0,0)));
    tab.push_back(row(i0, mk_out(0,0,0,0,0,0,0,0,32'h13,0,0)));
    tab.push_back(row(mk_in(0,0,0,0,0,0,0,32'h00100113),
      mk_out(0,0,0,0,0,0,0,0,32'h13,0,0)));
    tab.push_back(row(i0, mk_out(0,0,0,0,0,0,0,1,32'h00100113,0,0)));
    // partial-byte store, odd address
    tab.push_back(row(mk_in(0,0,1,1,32'h103,32'hA5A5,4'h6,0),
      mk_out(0,1,1,1,32'h103,32'hA5A5,4'h6,0,32'h00100113,0,0)));
    tab.push_back(row(i0, mk_out(0,0,0,0,0,0,0,0,32'h00100113,0,0)));
    tab.push_back(row(mk_in(0,0,0,0,0,0,0,32'h77),
      mk_out(0,0,0,0,0,0,0,0,32'h00100113,0,0)));
    tab.push_back(row(i0, mk_out(0,0,0,0,0,0,0,0,32'h00100113,1,0)));

    drive(mk_in(1,0,1,0,0,0,0,0));
    rst_n = 1'b0;
    @(negedge clk);
    #1 check("reset_state", z);
    @(negedge clk);
    drive(i0);
    rst_n = 1'b1;

    foreach (tab[k]) begin
      @(negedge clk);
      drive(tab[k].i);
      #1 check($sformatf("row%0d", k), tab[k].o);
    end

    // both requesters held high for 20 grants
    begin
      int ng;
      int cyc;
      logic exp_i;
      ng = 0;
      cyc = 0;
      @(negedge clk);
      drive(mk_in(1,32'h80,1,0,32'h40,0,4'hF,32'h5));
      while (ng < 20 && cyc < 200) begin
        #1;
        if (bus.d_gnt || bus.if_gnt) begin
`ifdef ARB_STARVE_GUARD_EN
          exp_i = (ng % 5) == 4;
`else
          exp_i = 1'b0;
`endif
          check_bit($sformatf("starve_gnt%0d", ng), bus.if_gnt, exp_i);
          ng++;
        end
        @(negedge clk);
        cyc++;
      end
      if (ng < 20) begin
        n_cmp++;
        n_err++;
        $display("FAIL starve_timeout: got %0d grants want 20", ng);
      end
      drive(i0);
      repeat (4) @(negedge clk);
    end

    // reset dropped during the WAIT of a fetch
    drive(mk_in(1,32'h20,0,0,0,0,0,0));
    #1 check_bit("rst_pre_gnt", bus.if_gnt, 1'b1);
    @(negedge clk);
    drive(i0);
    #2;
    drive(mk_in(1,32'h24,1,0,32'h30,0,4'hF,32'hBAD));
    rst_n = 1'b0;
    #1 check("rst_immediate", z);
    repeat (3) begin
      @(negedge clk);
      #1 check("rst_held", z);
    end
    @(negedge clk);
    drive(i0);
    rst_n = 1'b1;
    #1 check("rst_release", z);
    @(negedge clk);
    #1 check("rst_no_rvalid", z);
    @(negedge clk);
    drive(mk_in(1,32'h44,0,0,0,0,0,0));
    #1 check("rst_first_gnt", mk_out(1,0,1,0,32'h44,0,4'hF,0,0,0,0));
    @(negedge clk);
    drive(i0);
    #1 check("rst_wait", z);
    @(negedge clk);
    drive(mk_in(0,0,0,0,0,0,0,32'hCAFE0001));
    #1 check("rst_resp", z);
    @(negedge clk);
    drive(i0);
    #1 check("rst_rvalid", mk_out(0,0,0,0,0,0,0,1,32'hCAFE0001,0,0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the core's single shared byte-addressed memory port. It sits between the fetch stage (instruction reads) and the memory stage (loads and stores), which both target one memory array.
- It grants one transaction at a time and drives the memory port.
- It waits the memory's fixed read latency, then returns the result to the granted requester.
- Data accesses have priority over fetches.

## Interface
- ADDR_W, 32, address width for all ports.
- MEM_LAT, 2, cycles from memory issue to valid `mem_rdata`; legal range 1..8.
- STARVE_MAX, 4, consecutive data grants tolerated while a fetch waits; used only with ARB_STARVE_GUARD_EN.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous assertion, active-low.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch byte address.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  fetch data valid, one-cycle pulse.
- if_rdata  out  32  fetched word.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  32  store data.
- d_be  in  4  store byte enables.
- d_gnt  out  1  data accepted this cycle.
- d_rvalid  out  1  load data or store completion, one-cycle pulse.
- d_rdata  out  32  load word; 0 for stores.
- mem_req  out  1  memory issue strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  32  memory write data.
- mem_be  out  4  memory byte enables.
- mem_rdata  in  32  memory read data, valid MEM_LAT cycles after the `mem_req` cycle.

## Operation
- FSM states:
  - IDLE: arbitrates.
  - WAIT: counts the memory latency.
  - RESP: captures `mem_rdata`.
- IDLE with no request: stay in IDLE; all strobes are 0.
- IDLE with a request: the winner is selected combinationally.
  - Priority is `d_req` over `if_req`.
  - The winner's `x_gnt` is 1 in that cycle.
  - `mem_req` is 1 and `mem_*` are driven combinationally from the winner's inputs. A fetch forces `mem_we`=0 and `mem_be`=4'hF.
  - The owner is latched and the latency counter is loaded with MEM_LAT-1.
  - Next state is WAIT if MEM_LAT>1, otherwise RESP.
- WAIT: decrement the counter; go to RESP when it reaches 1.
- RESP (the cycle where `mem_rdata` is valid):
  - Register `mem_rdata` into the owner's rdata register. For a store owner, the d_rdata register is loaded with 0.
  - Set the owner's rvalid flop; go to IDLE.
- `x_rvalid` is a registered one-cycle pulse; `x_rdata` holds its last value until the next response to that requester.
- Requester rules:
  - Hold `x_req` until `x_gnt`.
  - Inputs are sampled only in the grant cycle.
  - A request still held after grant is a new request, serviced at the next IDLE.
- `mem_*` outputs are 0 in every cycle except the issue cycle.
- Addresses pass through unchecked; misalignment is the requester's concern.
- Requests arriving in WAIT or RESP are not granted and are not lost; they are seen in the next IDLE.

## Timing
- Reset (`rst_n`=0): state IDLE, counter 0, all outputs 0, rdata registers 0, starvation counter 0. Takes effect immediately, without waiting for a clock edge.
- Reset mid-transaction: the transaction is abandoned, no `x_rvalid` follows, and a late `mem_rdata` is ignored.
- Issue at cycle T. Data is captured at T+MEM_LAT and `x_rvalid` is asserted in T+MEM_LAT+1.
- A new grant is possible in T+MEM_LAT+1, the same cycle as `x_rvalid`.
- Maximum throughput: one transaction per MEM_LAT+1 cycles.
- Grant latency from `x_req` rising in IDLE: 0 cycles, combinational.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - A starvation counter increments on each data grant made while `if_req`=1.
  - When the counter equals STARVE_MAX, the next arbitration with `if_req`=1 grants the fetch regardless of `d_req`.
  - The counter clears on any fetch grant or any IDLE cycle with `if_req`=0.
- ARB_STARVE_GUARD_EN undefined:
  - Strict data priority; no counter logic.
  - STARVE_MAX is ignored.

## Test plan
- Single fetch, MEM_LAT=2: `if_req`=1, `if_addr`=0x8 at cycle 1, memory returns 0x00500093 at cycle 3.
  - Required: `if_gnt` and `mem_req` in cycle 1 with `mem_addr`=0x8, `mem_we`=0.
  - Required: `if_rvalid`=1 in cycle 4 with `if_rdata`=0x00500093.
- Simultaneous requests: `d_req` (load, 0x9) and `if_req` (0x0) both at cycle 1.
  - Required: `d_gnt` in cycle 1 and `d_rvalid` in cycle 4.
  - Required: `if_gnt` in cycle 4 and `if_rvalid` in cycle 7.
- Store: `d_we`=1, `d_addr`=0x9, `d_wdata`=14, `d_be`=4'hF.
  - Required in the grant cycle: `mem_we`=1, `mem_wdata`=0x0000000E, `mem_be`=4'hF.
  - Required: `d_rvalid` 3 cycles later with `d_rdata`=0.
- Back-to-back: `if_req` held high, address 0x0 then 0x4.
  - Required: grants at cycles 1 and 4, `if_rvalid` at cycles 4 and 7.
- Starvation, STARVE_MAX=4, `d_req` and `if_req` both held high.
  - With the macro: grant order D,D,D,D,I,D,D,D,D,I.
  - Without the macro: zero fetch grants over 20 transactions.
- Reset mid-operation: drop `rst_n` during WAIT of a fetch.
  - Required: all outputs 0 immediately and no `if_rvalid` afterwards.
  - Required: after release, a new `if_req` is granted in its first cycle.
